// File: rtl/ones_spreader.sv
// ---------------------------------------------------------------------------
// ones_spreader
//   Purpose     : takes a ones count over a valid/ready handshake and streams
//                 an N-bit frame, one bit per beat, with exactly that many
//                 ones spread evenly across the frame (Bresenham spacing).
//   Latency     : count accepted on edge t -> bit 0 presented right after t.
//   Backpressure: while out_valid & !out_ready, all beat state holds.
//
// Optional feature macro: ONES_SPREADER_BACK_TO_BACK_EN
//   defined     : in_ready also rises on the last-beat handshake, so a new
//                 frame starts on the next cycle with no bubble. This adds a
//                 combinational path out_ready -> in_ready.
//   not defined : in_ready is high only in IDLE; one idle cycle separates
//                 consecutive frames; in_ready is a pure function of state.
//
// Ports
//   clk        in   1              clock, rising edge
//   rst        in   1              synchronous reset, active-high
//   in_count   in   COUNT_WIDTH+1  requested ones count (saturates to N)
//   in_valid   in   1              in_count valid
//   in_ready   out  1              block can accept a new count
//   out_bit    out  1              current frame bit (bit 0 first)
//   out_valid  out  1              out_bit/out_last valid
//   out_ready  in   1              downstream accepts the beat
//   out_last   out  1              marks frame bit N-1
// ---------------------------------------------------------------------------
module ones_spreader #(
    parameter  int N           = 8,
    localparam int COUNT_WIDTH = $clog2(N)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [COUNT_WIDTH:0]   in_count,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic                   out_bit,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_last
);

    // Accumulator sum needs one extra bit: acc <= N-1 and c <= N, so
    // acc + c <= 2N-1.
    localparam int CW    = COUNT_WIDTH + 1;
    localparam int SUM_W = COUNT_WIDTH + 2;
    localparam int IDX_W = (COUNT_WIDTH < 1) ? 1 : COUNT_WIDTH;

    localparam logic [CW-1:0]    C_MAX    = CW'(N);
    localparam logic [SUM_W-1:0] N_SUM    = SUM_W'(N);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_STREAM = 1'b1
    } state_t;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    state_t            r_state;
    logic [CW-1:0]     r_c;      // captured (saturated) ones count
    logic [CW-1:0]     r_acc;    // Bresenham error accumulator, 0..N-1
    logic [IDX_W-1:0]  r_idx;    // beat index within frame, 0..N-1

    state_t            w_state_nxt;
    logic [CW-1:0]     w_c_nxt;
    logic [CW-1:0]     w_acc_nxt;
    logic [IDX_W-1:0]  w_idx_nxt;

    // -----------------------------------------------------------------------
    // Datapath
    // -----------------------------------------------------------------------
    logic              w_streaming;
    logic              w_is_last;
    logic [SUM_W-1:0]  w_sum;
    logic              w_bit;
    logic [CW-1:0]     w_acc_step;
    logic [CW-1:0]     w_count_sat;
    logic              w_in_hs;
    logic              w_out_hs;

    assign w_streaming = (r_state == S_STREAM);
    assign w_is_last   = (r_idx == IDX_LAST);

    // The current bit is derived from the held accumulator, so it stays
    // stable for free while the beat is stalled: acc only moves on a
    // completed output handshake.
    assign w_sum      = {1'b0, r_acc} + {1'b0, r_c};
    assign w_bit      = (w_sum >= N_SUM);
    assign w_acc_step = w_bit ? CW'(w_sum - N_SUM) : CW'(w_sum);

    assign w_count_sat = (in_count > C_MAX) ? C_MAX : in_count;

    // -----------------------------------------------------------------------
    // Handshakes
    // -----------------------------------------------------------------------
    assign out_valid = w_streaming;
    assign out_bit   = w_streaming & w_bit;
    assign out_last  = w_streaming & w_is_last;

    assign w_out_hs  = out_valid & out_ready;

`ifdef ONES_SPREADER_BACK_TO_BACK_EN
    assign in_ready  = (r_state == S_IDLE) | (w_out_hs & w_is_last);
`else
    assign in_ready  = (r_state == S_IDLE);
`endif

    assign w_in_hs   = in_valid & in_ready;

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_c_nxt     = r_c;
        w_acc_nxt   = r_acc;
        w_idx_nxt   = r_idx;

        case (r_state)
            S_IDLE: begin
                if (w_in_hs) begin
                    w_state_nxt = S_STREAM;
                    w_c_nxt     = w_count_sat;
                    w_acc_nxt   = '0;
                    w_idx_nxt   = '0;
                end
            end

            S_STREAM: begin
                if (w_out_hs) begin
                    w_acc_nxt = w_acc_step;
                    w_idx_nxt = r_idx + IDX_W'(1);
                    if (w_is_last) begin
                        w_state_nxt = S_IDLE;
                        w_idx_nxt   = '0;
`ifdef ONES_SPREADER_BACK_TO_BACK_EN
                        // A count taken on the last-beat edge restarts the
                        // frame directly, skipping the IDLE cycle.
                        if (w_in_hs) begin
                            w_state_nxt = S_STREAM;
                            w_c_nxt     = w_count_sat;
                            w_acc_nxt   = '0;
                        end
`endif
                    end
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_c     <= '0;
            r_acc   <= '0;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_c     <= w_c_nxt;
            r_acc   <= w_acc_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

endmodule
